// File: rtl/systolic.sv
// rtl/systolic.sv - 2x2 systolic array with matrix-multiply (accumulate) and FIR (product) modes
module systolic #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  func_sel,
    input  logic [DATA_WIDTH-1:0] i_data_11,
    input  logic [DATA_WIDTH-1:0] i_data_21,
    input  logic [DATA_WIDTH-1:0] i_fir_data_12,
    input  logic [DATA_WIDTH-1:0] i_fir_data_22,
    input  logic [DATA_WIDTH-1:0] i_tap_11,
    input  logic [DATA_WIDTH-1:0] i_tap_12,
    input  logic [DATA_WIDTH-1:0] i_fir_tap_21,
    input  logic [DATA_WIDTH-1:0] i_fir_tap_22,
    output logic [DATA_WIDTH-1:0] o_data_11,
    output logic [DATA_WIDTH-1:0] o_data_12,
    output logic [DATA_WIDTH-1:0] o_data_21,
    output logic [DATA_WIDTH-1:0] o_data_22
);

    // PE index: 0 = PE11, 1 = PE12, 2 = PE21, 3 = PE22
    logic [DATA_WIDTH-1:0] r_a_q [4];
    logic [DATA_WIDTH-1:0] r_b_q [4];
    logic [DATA_WIDTH-1:0] r_acc [4];
    logic [DATA_WIDTH-1:0] w_a_in [4];
    logic [DATA_WIDTH-1:0] w_b_in [4];
    logic [DATA_WIDTH-1:0] w_prod [4];

    always_comb begin
        w_a_in[0] = i_data_11;
        w_b_in[0] = i_tap_11;
        w_a_in[1] = func_sel ? i_fir_data_12 : r_a_q[0];
        w_b_in[1] = i_tap_12;
        w_a_in[2] = i_data_21;
        w_b_in[2] = func_sel ? i_fir_tap_21  : r_b_q[0];
        w_a_in[3] = func_sel ? i_fir_data_22 : r_a_q[2];
        w_b_in[3] = func_sel ? i_fir_tap_22  : r_b_q[1];
        // Truncation to DATA_WIDTH gives the same bits for signed and unsigned operands
        for (int i = 0; i < 4; i++) begin
            w_prod[i] = w_a_in[i] * w_b_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_a_q[i] <= '0;
                r_b_q[i] <= '0;
                r_acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_a_q[i] <= w_a_in[i];
                r_b_q[i] <= w_b_in[i];
                r_acc[i] <= func_sel ? w_prod[i] : r_acc[i] + w_prod[i];
            end
        end
    end

    assign o_data_11 = r_acc[0];
    assign o_data_12 = r_acc[1];
    assign o_data_21 = r_acc[2];
    assign o_data_22 = r_acc[3];

endmodule

// File: tb/tb_systolic.sv
// tb/tb_systolic.sv - directed self-checking bench for systolic
module tb_systolic;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          func_sel;
    logic [DW-1:0] d11, d21, fd12, fd22, t11, t12, ft21, ft22;
    logic [DW-1:0] o11, o12, o21, o22;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    systolic #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .func_sel     (func_sel),
        .i_data_11    (d11),
        .i_data_21    (d21),
        .i_fir_data_12(fd12),
        .i_fir_data_22(fd22),
        .i_tap_11     (t11),
        .i_tap_12     (t12),
        .i_fir_tap_21 (ft21),
        .i_fir_tap_22 (ft22),
        .o_data_11    (o11),
        .o_data_12    (o12),
        .o_data_21    (o21),
        .o_data_22    (o22)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        d11 = '0; d21 = '0; fd12 = '0; fd22 = '0;
        t11 = '0; t12 = '0; ft21 = '0; ft22 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        zero_inputs();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [DW-1:0] obs [4];
        func_sel = 1'b0;
        rst = 1'b0;
        d11 = 7; d21 = 7; fd12 = 7; fd22 = 7; t11 = 3; t12 = 3; ft21 = 3; ft22 = 3;
        for (int c = 0; c < 2; c++) begin
            step();
            obs = '{o11, o12, o21, o22};
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (obs[i] !== '0) begin
                    n_err++;
                    $display("FAIL reset cyc%0d pe%0d got %h expected 0", c, i, obs[i]);
                end
            end
        end
        rst = 1'b1;
        zero_inputs();
    endtask

    task automatic test_matrix(input string name);
        // per cycle: {d11, t11, d21, t12} and expected {o11, o12, o21, o22} after the edge
        logic [DW-1:0] stim [6][4];
        logic [DW-1:0] expv [6][4];
        logic [DW-1:0] obs  [4];
        stim = '{'{1,1,0,0}, '{2,2,1,1}, '{0,0,2,2}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
        expv = '{'{1,0,0,0}, '{5,1,1,0}, '{5,5,5,1}, '{5,5,5,5}, '{5,5,5,5}, '{5,5,5,5}};
        func_sel = 1'b0;
        for (int c = 0; c < 6; c++) begin
            d11 = stim[c][0]; t11 = stim[c][1]; d21 = stim[c][2]; t12 = stim[c][3];
            step();
            obs = '{o11, o12, o21, o22};
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (obs[i] !== expv[c][i]) begin
                    n_err++;
                    $display("FAIL %s cyc%0d pe%0d got %0d expected %0d", name, c, i, obs[i], expv[c][i]);
                end
            end
        end
        zero_inputs();
    endtask

    task automatic test_fir();
        logic [DW-1:0] obs  [4];
        logic [DW-1:0] expv [4];
        func_sel = 1'b1;
        d11 = 3; t11 = 4; fd12 = 5; t12 = 6; d21 = 7; ft21 = 2; fd22 = 9; ft22 = 9;
        step();
        obs = '{o11, o12, o21, o22};
        expv = '{32'd12, 32'd30, 32'd14, 32'd81};
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs[i] !== expv[i]) begin
                n_err++;
                $display("FAIL fir pe%0d got %0d expected %0d", i, obs[i], expv[i]);
            end
        end
        zero_inputs();
        step();
        obs = '{o11, o12, o21, o22};
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs[i] !== '0) begin
                n_err++;
                $display("FAIL fir_zero pe%0d got %0d expected 0", i, obs[i]);
            end
        end
    endtask

    task automatic test_overflow();
        func_sel = 1'b1;
        d11 = 32'hFFFF_FFFF; t11 = 2;
        step();
        n_vec++;
        if (o11 !== 32'hFFFF_FFFE) begin
            n_err++;
            $display("FAIL ovf_fir got %h expected fffffffe", o11);
        end
        do_reset();
        func_sel = 1'b0;
        d11 = 32'h8000_0000; t11 = 2;
        step();
        n_vec++;
        if (o11 !== 32'h0) begin
            n_err++;
            $display("FAIL ovf_mul got %h expected 00000000", o11);
        end
        d11 = 32'hFFFF_FFFF; t11 = 1;
        step();
        n_vec++;
        if (o11 !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL ovf_acc1 got %h expected ffffffff", o11);
        end
        d11 = 1; t11 = 1;
        step();
        n_vec++;
        if (o11 !== 32'h0) begin
            n_err++;
            $display("FAIL ovf_acc_wrap got %h expected 00000000", o11);
        end
        zero_inputs();
    endtask

    task automatic test_mode_switch();
        func_sel = 1'b1;
        d11 = 3; t11 = 4;
        step();
        n_vec++;
        if (o11 !== 32'd12) begin
            n_err++;
            $display("FAIL mode_fir got %0d expected 12", o11);
        end
        func_sel = 1'b0;
        d11 = 1; t11 = 1;
        step();
        n_vec++;
        if (o11 !== 32'd13) begin
            n_err++;
            $display("FAIL mode_carry got %0d expected 13", o11);
        end
        zero_inputs();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] obs [4];
        func_sel = 1'b0;
        d11 = 1; t11 = 1;
        step();
        d11 = 2; t11 = 2; d21 = 1; t12 = 1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            obs = '{o11, o12, o21, o22};
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (obs[i] !== '0) begin
                    n_err++;
                    $display("FAIL reset_mid cyc%0d pe%0d got %0d expected 0", c, i, obs[i]);
                end
            end
        end
        rst = 1'b1;
        zero_inputs();
        test_matrix("matrix_after_reset");
    endtask

    task automatic test_propagation();
        logic [DW-1:0] expv [3][4];
        logic [DW-1:0] obs  [4];
        expv = '{'{1,0,0,0}, '{1,1,1,0}, '{1,1,1,1}};
        func_sel = 1'b0;
        for (int c = 0; c < 3; c++) begin
            zero_inputs();
            if (c == 0) begin
                d11 = 1; t11 = 1;
            end else if (c == 1) begin
                t12 = 1; d21 = 1;
            end
            step();
            obs = '{o11, o12, o21, o22};
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (obs[i] !== expv[c][i]) begin
                    n_err++;
                    $display("FAIL prop edge%0d pe%0d got %0d expected %0d", c + 1, i, obs[i], expv[c][i]);
                end
            end
        end
        zero_inputs();
    endtask

    initial begin
        rst = 1'b0;
        func_sel = 1'b0;
        zero_inputs();
        #2;
        test_reset();
        test_matrix("matrix");
        do_reset();
        test_fir();
        do_reset();
        test_overflow();
        do_reset();
        test_mode_switch();
        do_reset();
        test_reset_mid();
        do_reset();
        test_propagation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/systolic.md
SYSTOLIC -- requirements
Module: systolic

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of all data, tap and output buses.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 func_sel  input  1  mode select: 0 = matrix multiplication, 1 = FIR.
REQ-005 i_data_11  input  DATA_WIDTH  row-1 data into PE11.
REQ-006 i_data_21  input  DATA_WIDTH  row-2 data into PE21.
REQ-007 i_fir_data_12  input  DATA_WIDTH  FIR-mode data into PE12.
REQ-008 i_fir_data_22  input  DATA_WIDTH  FIR-mode data into PE22.
REQ-009 i_tap_11  input  DATA_WIDTH  column-1 tap into PE11.
REQ-010 i_tap_12  input  DATA_WIDTH  column-2 tap into PE12.
REQ-011 i_fir_tap_21  input  DATA_WIDTH  FIR-mode tap into PE21.
REQ-012 i_fir_tap_22  input  DATA_WIDTH  FIR-mode tap into PE22.
REQ-013 o_data_11/o_data_12/o_data_21/o_data_22  output  DATA_WIDTH each  registered result of the corresponding PE.

Function
REQ-014 Array SHALL be 2x2 processing elements (PEij, i = row, j = column); each PE holds data-pass register a_q, tap-pass register b_q and result register acc, all DATA_WIDTH.
REQ-015 Each PE, per clock: a_q <= a_in, b_q <= b_in; a_q/b_q update in both modes.
REQ-016 Matrix mode (func_sel=0): acc <= acc + a_in*b_in (accumulate, output-stationary).
REQ-017 FIR mode (func_sel=1): acc <= a_in*b_in (no accumulation; acc overwritten by product each cycle).
REQ-018 Matrix-mode operand routing: PE11 a_in=i_data_11, b_in=i_tap_11; PE12 a_in=PE11.a_q, b_in=i_tap_12; PE21 a_in=i_data_21, b_in=PE11.b_q; PE22 a_in=PE21.a_q, b_in=PE12.b_q.
REQ-019 FIR-mode operand routing: PE11 a_in=i_data_11, b_in=i_tap_11; PE12 a_in=i_fir_data_12, b_in=i_tap_12; PE21 a_in=i_data_21, b_in=i_fir_tap_21; PE22 a_in=i_fir_data_22, b_in=i_fir_tap_22.
REQ-020 Routing SHALL follow func_sel combinationally in the same cycle; mode change takes effect on the next rising edge with no flush; acc carries over (matrix mode after FIR continues accumulating from last product).
REQ-021 o_data_ij SHALL equal PEij.acc directly (register output, no combinational path from inputs).
REQ-022 Latency: an operand pair presented at PE inputs before edge k SHALL be reflected in o_data at edge k (1 cycle); horizontal/vertical neighbour hop adds 1 cycle per PE.
REQ-023 Arithmetic: multiply and add SHALL be modulo 2^DATA_WIDTH (low DATA_WIDTH bits kept, wrap-around, no saturation, no overflow flag); signed and unsigned interpretation give identical bits.
REQ-024 Host feeds row-2 data and column-2 taps skewed one cycle later than row/column 1; the block itself SHALL not insert skew on external inputs.
REQ-025 Inputs of zero SHALL leave matrix-mode acc unchanged (drain phase holds results).

Reset
REQ-026 When rst=0 at a rising edge, all a_q, b_q and acc in all four PEs SHALL clear to 0; all o_data = 0 from that edge.
REQ-027 Reset SHALL take priority over any computation, including mid-accumulation; outputs remain 0 while rst=0 held.
REQ-028 State before the first reset edge is undefined; no asynchronous clear.

Verification
REQ-029 Matrix 2x2: func_sel=0; i_data_11/i_tap_11 = 1,2 on consecutive cycles then 0; i_data_21/i_tap_12 = 1,2 one cycle later then 0 -> after drain all four outputs = 5 and stay 5.
REQ-030 FIR: func_sel=1; inputs (11)=3x4, (12)=5x6, (21)=7x2, (22)=9x9 held one cycle -> next edge o_data = 12, 30, 14, 81; next cycle with zero inputs all outputs 0.
REQ-031 Overflow: func_sel=1, i_data_11=0xFFFFFFFF, i_tap_11=2 -> o_data_11=0xFFFFFFFE; matrix mode accumulate 0x80000000*2 -> acc wraps to 0.
REQ-032 Reset mid-operation: accumulate to nonzero values, assert rst=0 one cycle -> all outputs 0 at that edge; release and rerun REQ-029 stimulus -> 5 again.
REQ-033 Propagation: func_sel=0, single pulse i_data_11=1, i_tap_11=1 at cycle 0, i_tap_12=1 at cycle 1, i_data_21=1 at cycle 1 -> o_data_11=1 at edge 1, o_data_12 and o_data_21=1 at edge 2, o_data_22=1 at edge 3.
